// File: rtl/mod_voice_alloc.sv
// Polyphonic voice allocator: assigns note-on/off events to voice slots,
// retriggering matching notes and stealing the least-recently-triggered voice.
`timescale 1ns/1ps
module mod_voice_alloc #(
  parameter int NUM_VOICES = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_evt_valid,
  output logic                                o_evt_ready,
  input  logic                                i_evt_on,
  input  logic [6:0]                          i_evt_note,
  input  logic [6:0]                          i_evt_vel,
  output logic [NUM_VOICES-1:0]               o_voice_gate,
  output logic [7*NUM_VOICES-1:0]             o_voice_note,
  output logic [7*NUM_VOICES-1:0]             o_voice_vel,
  output logic                                o_steal,
  output logic [$clog2(NUM_VOICES+1)-1:0]     o_active_count
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(NUM_VOICES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t state, state_next;

  logic          lat_on;
  logic [6:0]    lat_note;
  logic [6:0]    lat_vel;
  logic [IW-1:0] scan_idx;
  logic          match_found;
  logic [IW-1:0] match_idx;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] oldest_idx;
  logic          steal;

  logic [NUM_VOICES-1:0] gate;
  logic [6:0]            note [NUM_VOICES];
  logic [6:0]            vel  [NUM_VOICES];
  logic [IW-1:0]         rank [NUM_VOICES];

  logic [IW-1:0] target;
  logic          is_on;
  logic [CW-1:0] count_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_evt_valid) state_next = SCAN;
      SCAN:    if (scan_idx == LAST) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_evt_ready = (state == IDLE);

  // A velocity-0 note-on is a note-off; the target follows match > free > oldest.
  always_comb begin
    is_on  = lat_on && (lat_vel != 7'd0);
    target = oldest_idx;
    if (match_found) begin
      target = match_idx;
    end else if (free_found) begin
      target = free_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lat_on      <= 1'b0;
      lat_note    <= '0;
      lat_vel     <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      oldest_idx  <= '0;
      steal       <= 1'b0;
      gate        <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note[i] <= '0;
        vel[i]  <= '0;
        rank[i] <= IW'(i);
      end
    end else begin
      steal <= 1'b0;
      case (state)
        IDLE: begin
          if (i_evt_valid) begin
            lat_on      <= i_evt_on;
            lat_note    <= i_evt_note;
            lat_vel     <= i_evt_vel;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
          end
        end
        SCAN: begin
          if (gate[scan_idx] && (note[scan_idx] == lat_note) && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!gate[scan_idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (rank[scan_idx] == LAST) begin
            oldest_idx <= scan_idx;
          end
          scan_idx <= scan_idx + 1'b1;
        end
        COMMIT: begin
          if (is_on) begin
            gate[target] <= 1'b1;
            note[target] <= lat_note;
            vel[target]  <= lat_vel;
            steal        <= !match_found && !free_found;
            // Move the target to the front of the recency order.
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (IW'(v) == target) begin
                rank[v] <= '0;
              end else if (rank[v] < rank[target]) begin
                rank[v] <= rank[v] + 1'b1;
              end
            end
          end else if (match_found) begin
            gate[match_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      count_next = count_next + CW'(gate[i]);
    end
  end

  // Outputs are a registered copy of the voice state, so they land one edge after COMMIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_voice_gate   <= '0;
      o_voice_note   <= '0;
      o_voice_vel    <= '0;
      o_steal        <= 1'b0;
      o_active_count <= '0;
    end else begin
      o_voice_gate <= gate;
      for (int i = 0; i < NUM_VOICES; i++) begin
        o_voice_note[7*i +: 7] <= note[i];
        o_voice_vel[7*i +: 7]  <= vel[i];
      end
      o_steal        <= steal;
      o_active_count <= count_next;
    end
  end

endmodule

// File: tb/tb_mod_voice_alloc.sv
// Self-checking bench for mod_voice_alloc against a recency-queue voice model.
`timescale 1ns/1ps
module tb_mod_voice_alloc;

  localparam int NV = 4;
  localparam int CW = $clog2(NV + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_on;
  logic [6:0]      evt_note;
  logic [6:0]      evt_vel;
  logic [NV-1:0]   voice_gate;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_vel;
  logic            steal;
  logic [CW-1:0]   active_count;

  int errors = 0;
  int checks = 0;

  mod_voice_alloc #(.NUM_VOICES(NV)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_evt_valid    (evt_valid),
    .o_evt_ready    (evt_ready),
    .i_evt_on       (evt_on),
    .i_evt_note     (evt_note),
    .i_evt_vel      (evt_vel),
    .o_voice_gate   (voice_gate),
    .o_voice_note   (voice_note),
    .o_voice_vel    (voice_vel),
    .o_steal        (steal),
    .o_active_count (active_count)
  );

  always #5 clk = ~clk;

  // Reference model: per-voice slots plus a recency queue (front = newest).
  bit         m_gate [NV];
  logic [6:0] m_note [NV];
  logic [6:0] m_vel  [NV];
  int         order  [$];

  function automatic void model_reset();
    order.delete();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0;
      m_note[i] = '0;
      m_vel[i]  = '0;
      order.push_back(i);
    end
  endfunction

  function automatic bit model_apply(input bit on, input logic [6:0] n, input logic [6:0] v);
    int t = -1;
    bit st = 1'b0;
    for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
    if (!on || v == 7'd0) begin
      if (t >= 0) m_gate[t] = 1'b0;
      return 1'b0;
    end
    for (int i = 0; i < NV; i++) if (t < 0 && !m_gate[i]) t = i;
    if (t < 0) begin
      t  = order[order.size()-1];
      st = 1'b1;
    end
    for (int j = 0; j < order.size(); j++) begin
      if (order[j] == t) begin
        order.delete(j);
        break;
      end
    end
    order.push_front(t);
    m_gate[t] = 1'b1;
    m_note[t] = n;
    m_vel[t]  = v;
    return st;
  endfunction

  function automatic logic [NV-1:0] exp_gate();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_gate[i];
    return r;
  endfunction

  function automatic logic [7*NV-1:0] exp_notes();
    logic [7*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[7*i +: 7] = m_note[i];
    return r;
  endfunction

  function automatic logic [7*NV-1:0] exp_vels();
    logic [7*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[7*i +: 7] = m_vel[i];
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_count();
    int c = 0;
    for (int i = 0; i < NV; i++) c += int'(m_gate[i]);
    return CW'(c);
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    evt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Presents one event, waits for acceptance, then watches the next 7 edges.
  task automatic send_event(input bit on, input logic [6:0] n, input logic [6:0] v,
                            output int upd_edge, output int steal_cnt,
                            output int steal_edge, output int rdy_edge,
                            output bit exp_steal);
    logic [NV+14*NV+CW-1:0] snap;
    int waited = 0;
    upd_edge = 0; steal_cnt = 0; steal_edge = 0; rdy_edge = -1; exp_steal = 1'b0;
    @(negedge clk);
    evt_valid = 1'b1; evt_on = on; evt_note = n; evt_vel = v;
    while (!evt_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!evt_ready) begin
      errors++;
      $display("[TB] FAIL accept_timeout: ready=%0b after %0d cycles, required 1", evt_ready, waited);
      evt_valid = 1'b0;
      return;
    end
    snap = {voice_gate, voice_note, voice_vel, active_count};
    @(posedge clk);
    #1 evt_valid = 1'b0;
    exp_steal = model_apply(on, n, v);
    if (steal) begin steal_cnt++; steal_edge = 0; end
    if (evt_ready) rdy_edge = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (steal) begin steal_cnt++; steal_edge = k; end
      if (evt_ready && rdy_edge < 0) rdy_edge = k;
      if (upd_edge == 0 && {voice_gate, voice_note, voice_vel, active_count} != snap) upd_edge = k;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (voice_gate !== '0 || active_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_gate: gate=%b count=%0d, required 0/0", voice_gate, active_count);
    end
    checks++;
    if (voice_note !== '0 || voice_vel !== '0) begin
      errors++;
      $display("[TB] FAIL reset_note_vel: note=%h vel=%h, required 0", voice_note, voice_vel);
    end
    checks++;
    if (steal !== 1'b0 || evt_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: steal=%b ready=%b, required 0/1", steal, evt_ready);
    end
  endtask

  task automatic test_fill();
    logic [6:0] notes [4] = '{7'd60, 7'd62, 7'd64, 7'd67};
    logic [6:0] vels  [4] = '{7'd100, 7'd90, 7'd80, 7'd70};
    int ue, sc, se, re;
    bit es;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_event(1'b1, notes[i], vels[i], ue, sc, se, re, es);
      checks++;
      if (ue != 6 || re != 5) begin
        errors++;
        $display("[TB] FAIL fill_timing[%0d]: update_edge=%0d ready_edge=%0d, required 6/5", i, ue, re);
      end
      checks++;
      if (sc != 0) begin
        errors++;
        $display("[TB] FAIL fill_steal[%0d]: pulses=%0d, required 0", i, sc);
      end
      checks++;
      if (voice_gate !== NV'((1 << (i + 1)) - 1) || active_count !== CW'(i + 1)) begin
        errors++;
        $display("[TB] FAIL fill_gate[%0d]: gate=%b count=%0d, required %b/%0d",
                 i, voice_gate, active_count, NV'((1 << (i + 1)) - 1), i + 1);
      end
      checks++;
      if (voice_note[7*i +: 7] !== notes[i] || voice_vel[7*i +: 7] !== vels[i]) begin
        errors++;
        $display("[TB] FAIL fill_voice[%0d]: note=%0d vel=%0d, required %0d/%0d",
                 i, voice_note[7*i +: 7], voice_vel[7*i +: 7], notes[i], vels[i]);
      end
    end
  endtask

  task automatic test_steal();
    int ue, sc, se, re;
    bit es;
    send_event(1'b1, 7'd72, 7'd50, ue, sc, se, re, es);
    checks++;
    if (sc != 1 || se != 6) begin
      errors++;
      $display("[TB] FAIL steal_pulse: pulses=%0d at edge %0d, required 1 at 6", sc, se);
    end
    checks++;
    if (voice_note[6:0] !== 7'd72 || voice_vel[6:0] !== 7'd50 || active_count !== CW'(4)) begin
      errors++;
      $display("[TB] FAIL steal_voice0: note=%0d vel=%0d count=%0d, required 72/50/4",
               voice_note[6:0], voice_vel[6:0], active_count);
    end
    send_event(1'b1, 7'd74, 7'd60, ue, sc, se, re, es);
    checks++;
    if (sc != 1 || voice_note[13:7] !== 7'd74 || voice_note !== exp_notes()) begin
      errors++;
      $display("[TB] FAIL steal_voice1: pulses=%0d notes=%h, required 1/%h", sc, voice_note, exp_notes());
    end
  endtask

  task automatic test_retrigger();
    int ue, sc, se, re;
    bit es;
    do_reset();
    send_event(1'b1, 7'd60, 7'd100, ue, sc, se, re, es);
    send_event(1'b1, 7'd60, 7'd40, ue, sc, se, re, es);
    checks++;
    if (voice_gate !== 4'b0001 || voice_vel[6:0] !== 7'd40 || active_count !== CW'(1)) begin
      errors++;
      $display("[TB] FAIL retrigger: gate=%b vel0=%0d count=%0d, required 0001/40/1",
               voice_gate, voice_vel[6:0], active_count);
    end
    send_event(1'b1, 7'd60, 7'd0, ue, sc, se, re, es);
    checks++;
    if (voice_gate !== 4'b0000 || voice_note[6:0] !== 7'd60 || active_count !== CW'(0) || sc != 0) begin
      errors++;
      $display("[TB] FAIL vel0_off: gate=%b note0=%0d count=%0d steal=%0d, required 0000/60/0/0",
               voice_gate, voice_note[6:0], active_count, sc);
    end
  endtask

  task automatic test_note_off();
    int ue, sc, se, re;
    bit es;
    do_reset();
    send_event(1'b1, 7'd60, 7'd100, ue, sc, se, re, es);
    send_event(1'b1, 7'd62, 7'd90, ue, sc, se, re, es);
    send_event(1'b1, 7'd64, 7'd80, ue, sc, se, re, es);
    send_event(1'b0, 7'd50, 7'd10, ue, sc, se, re, es);
    checks++;
    if (ue != 0 || voice_gate !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL off_unallocated: change_edge=%0d gate=%b, required 0/0111", ue, voice_gate);
    end
    send_event(1'b0, 7'd62, 7'd10, ue, sc, se, re, es);
    checks++;
    if (voice_gate !== 4'b0101 || active_count !== CW'(2) || voice_note[13:7] !== 7'd62) begin
      errors++;
      $display("[TB] FAIL off_62: gate=%b count=%0d note1=%0d, required 0101/2/62",
               voice_gate, active_count, voice_note[13:7]);
    end
    send_event(1'b1, 7'd65, 7'd33, ue, sc, se, re, es);
    checks++;
    if (voice_gate !== 4'b0111 || voice_note[13:7] !== 7'd65 || voice_vel[13:7] !== 7'd33) begin
      errors++;
      $display("[TB] FAIL reuse_free: gate=%b note1=%0d vel1=%0d, required 0111/65/33",
               voice_gate, voice_note[13:7], voice_vel[13:7]);
    end
  endtask

  task automatic test_back_to_back();
    bit         ev_on   [3] = '{1'b1, 1'b1, 1'b0};
    logic [6:0] ev_note [3] = '{7'd40, 7'd41, 7'd40};
    logic [6:0] ev_vel  [3] = '{7'd11, 7'd22, 7'd33};
    int acc [$];
    int cyc = 0;
    int idx = 0;
    bit r;
    do_reset();
    @(negedge clk);
    evt_valid = 1'b1; evt_on = ev_on[0]; evt_note = ev_note[0]; evt_vel = ev_vel[0];
    while (idx < 3 && cyc < 60) begin
      r = evt_ready;
      @(posedge clk);
      cyc++;
      if (r) begin
        acc.push_back(cyc);
        void'(model_apply(ev_on[idx], ev_note[idx], ev_vel[idx]));
        idx++;
        #1;
        if (idx < 3) begin
          evt_on = ev_on[idx]; evt_note = ev_note[idx]; evt_vel = ev_vel[idx];
        end else begin
          evt_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    evt_valid = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("[TB] FAIL burst_accepts: accepted=%0d, required 3", idx);
    end else begin
      checks++;
      if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
        errors++;
        $display("[TB] FAIL burst_spacing: gaps=%0d,%0d, required 6,6", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (voice_gate !== exp_gate() || voice_note !== exp_notes() || voice_vel !== exp_vels()) begin
      errors++;
      $display("[TB] FAIL burst_order: gate=%b notes=%h vels=%h, required %b/%h/%h",
               voice_gate, voice_note, voice_vel, exp_gate(), exp_notes(), exp_vels());
    end
  endtask

  task automatic test_reset_mid_scan();
    int ue, sc, se, re;
    bit es;
    do_reset();
    send_event(1'b1, 7'd60, 7'd100, ue, sc, se, re, es);
    send_event(1'b1, 7'd62, 7'd90, ue, sc, se, re, es);
    @(negedge clk);
    evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd70; evt_vel = 7'd80;
    @(posedge clk);
    #1 evt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    checks++;
    if (voice_gate !== '0 || voice_note !== '0 || voice_vel !== '0 || active_count !== '0 || steal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midscan_reset: gate=%b note=%h vel=%h count=%0d steal=%b, required all 0",
               voice_gate, voice_note, voice_vel, active_count, steal);
    end
    checks++;
    if (evt_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midscan_ready: ready=%b, required 1", evt_ready);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (voice_gate !== '0 || voice_note !== '0) begin
      errors++;
      $display("[TB] FAIL midscan_dropped: gate=%b note=%h, required 0/0", voice_gate, voice_note);
    end
    for (int i = 0; i < NV; i++) send_event(1'b1, 7'(80 + i), 7'd5, ue, sc, se, re, es);
    send_event(1'b1, 7'd90, 7'd6, ue, sc, se, re, es);
    checks++;
    if (sc != 1 || voice_note[6:0] !== 7'd90 || voice_note !== exp_notes()) begin
      errors++;
      $display("[TB] FAIL midscan_ranks: steal=%0d notes=%h, required 1/%h", sc, voice_note, exp_notes());
    end
  endtask

  task automatic test_random();
    int ue, sc, se, re;
    bit es, on;
    logic [6:0] n, v;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      on = ($urandom_range(0, 3) != 0);
      n  = 7'(60 + $urandom_range(0, 5));
      v  = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      send_event(on, n, v, ue, sc, se, re, es);
      checks++;
      if (voice_gate !== exp_gate() || active_count !== exp_count()) begin
        errors++;
        $display("[TB] FAIL rand_gate[%0d]: gate=%b count=%0d, required %b/%0d",
                 it, voice_gate, active_count, exp_gate(), exp_count());
      end
      checks++;
      if (voice_note !== exp_notes() || voice_vel !== exp_vels()) begin
        errors++;
        $display("[TB] FAIL rand_voices[%0d]: notes=%h vels=%h, required %h/%h",
                 it, voice_note, voice_vel, exp_notes(), exp_vels());
      end
      checks++;
      if (sc != int'(es)) begin
        errors++;
        $display("[TB] FAIL rand_steal[%0d]: pulses=%0d, required %0d", it, sc, int'(es));
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    evt_valid = 1'b0;
    evt_on    = 1'b0;
    evt_note  = '0;
    evt_vel   = '0;
    model_reset();
    test_reset();
    test_fill();
    test_steal();
    test_retrigger();
    test_note_off();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
